// File: rtl/spart_pkg.sv
// rtl/spart_pkg.sv - shared constants, state encodings and helpers for the SPART
package spart_pkg;

  // Bus register addresses
  localparam logic [1:0] ADDR_DATA   = 2'b00;
  localparam logic [1:0] ADDR_STATUS = 2'b01;
  localparam logic [1:0] ADDR_DBL    = 2'b10;
  localparam logic [1:0] ADDR_DBH    = 2'b11;

  // Status register bit positions; bit 4 is parity_err or tx_count_sat[0]
  localparam int ST_RDA       = 0;
  localparam int ST_TBR       = 1;
  localparam int ST_RX_OVR    = 2;
  localparam int ST_FRAME_ERR = 3;
  localparam int ST_BIT4      = 4;

  // Baud ticks per bit and the tick at which the start bit is re-checked
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_BREAK
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  // Clamp a FIFO occupancy to the 4-bit status field
  function automatic logic [3:0] sat15(input logic [6:0] n);
    return (n > 7'd15) ? 4'd15 : n[3:0];
  endfunction

endpackage

// File: rtl/spart_sync_fifo.sv
// rtl/spart_sync_fifo.sv - single-clock FIFO with occupancy count, drops pushes when full
module spart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // Storage write; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/spart_fifo.sv
// rtl/spart_fifo.sv - SPART serial port with TX/RX FIFOs; define SPART_PARITY_EN for even parity
module spart_fifo
  import spart_pkg::*;
#(
  parameter int          DATA_BITS   = 8,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  input  logic       rxd,
  output logic       txd,
  output logic       rda,
  output logic       tbr
);

  localparam int         AW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

  logic [15:0]          divisor;
  logic [15:0]          baud_cnt;
  logic [7:0]           div_lo;
  logic                 tick;
  logic                 bus_rd;
  logic                 bus_wr;
  logic                 status_rd;
  logic [7:0]           rd_data;
  logic [7:0]           status;
  logic [3:0]           tx_sat;
  logic                 frame_err;
  logic                 rx_ovr;
  logic                 rx_done;
  logic                 frame_set;
  logic                 ovr_set;
  logic [DATA_BITS-1:0] tx_head;
  logic [DATA_BITS-1:0] rx_head;
  logic [DATA_BITS-1:0] tx_shift;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 tx_push;
  logic                 tx_pop;
  logic                 tx_full;
  logic                 tx_empty;
  logic                 rx_push;
  logic                 rx_pop;
  logic                 rx_full;
  logic                 rx_empty;
  logic [AW:0]          tx_count;
  logic [AW:0]          rx_count;
  tx_state_t            tx_state;
  rx_state_t            rx_state;
  logic [3:0]           tx_tick;
  logic [3:0]           rx_tick;
  logic [2:0]           tx_bit;
  logic [2:0]           rx_bit;
  logic                 rxd_meta;
  logic                 rxd_s;
`ifdef SPART_PARITY_EN
  logic                 tx_par;
  logic                 rx_par;
  logic                 parity_err;
  logic                 par_set;
`endif

  assign tick      = (baud_cnt == 16'd0);
  assign bus_rd    = iocs && iorw;
  assign bus_wr    = iocs && !iorw;
  assign status_rd = bus_rd && (ioaddr == ADDR_STATUS);
  assign databus   = bus_rd ? rd_data : 8'bz;

  assign tx_push = bus_wr && (ioaddr == ADDR_DATA);
  assign rx_pop  = bus_rd && (ioaddr == ADDR_DATA) && !rx_empty;
  assign tx_pop  = !tx_empty && ((tx_state == TX_IDLE) ||
                   ((tx_state == TX_STOP) && tick && (tx_tick == LAST_TICK)));

  // Receiver completes a frame on the stop-bit mid sample
  assign rx_done   = tick && (rx_state == RX_STOP) && (rx_tick == LAST_TICK);
  assign rx_push   = rx_done && rxd_s && !rx_full;
  assign ovr_set   = rx_done && rxd_s && rx_full;
  assign frame_set = rx_done && !rxd_s;
`ifdef SPART_PARITY_EN
  assign par_set   = rx_done && rxd_s && (rx_par != ^rx_shift);
`endif

  assign rda    = |rx_count;
  assign tbr    = !tx_full;
  assign tx_sat = sat15(7'(tx_count));

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (databus[DATA_BITS-1:0]),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .count     (tx_count)
  );

  spart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_shift),
    .pop       (rx_pop),
    .pop_data  (rx_head),
    .full      (rx_full),
    .empty     (rx_empty),
    .count     (rx_count)
  );

  // Status word; parity builds trade the low count bit for parity_err
  always_comb begin
`ifdef SPART_PARITY_EN
    status = {tx_sat[3:1], parity_err, frame_err, rx_ovr, tbr, rda};
`else
    status = {tx_sat, frame_err, rx_ovr, tbr, rda};
`endif
  end

  // Read mux; an empty RX FIFO reads as zero
  always_comb begin
    rd_data = 8'h00;
    unique case (ioaddr)
      ADDR_DATA:   if (!rx_empty) rd_data[DATA_BITS-1:0] = rx_head;
      ADDR_STATUS: rd_data = status;
      ADDR_DBL:    rd_data = divisor[7:0];
      ADDR_DBH:    rd_data = divisor[15:8];
    endcase
  end

  // Divisor registers and free-running baud down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      divisor  <= DEFAULT_DIV;
      div_lo   <= DEFAULT_DIV[7:0];
      baud_cnt <= DEFAULT_DIV;
    end else begin
      if (bus_wr && (ioaddr == ADDR_DBL)) div_lo <= databus;
      if (bus_wr && (ioaddr == ADDR_DBH)) begin
        divisor  <= {databus, div_lo};
        baud_cnt <= {databus, div_lo};
      end else if (tick) begin
        baud_cnt <= divisor;
      end else begin
        baud_cnt <= baud_cnt - 16'd1;
      end
    end
  end

  // Sticky error flags; a set in the same cycle as a status read wins
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_err <= 1'b0;
      rx_ovr    <= 1'b0;
`ifdef SPART_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (status_rd) frame_err <= 1'b0;
      if (ovr_set)        rx_ovr <= 1'b1;
      else if (status_rd) rx_ovr <= 1'b0;
`ifdef SPART_PARITY_EN
      if (par_set)        parity_err <= 1'b1;
      else if (status_rd) parity_err <= 1'b0;
`endif
    end
  end

  // Two-flop synchroniser for the asynchronous serial input
  always_ff @(posedge clk) begin
    if (rst) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
    end else begin
      rxd_meta <= rxd;
      rxd_s    <= rxd_meta;
    end
  end

  // Transmitter: each bit held 16 ticks; a waiting character follows the stop bit directly
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= TX_IDLE;
      txd      <= 1'b1;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= '0;
`ifdef SPART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else if (tx_pop) begin
      tx_shift <= tx_head;
      txd      <= 1'b0;
      tx_tick  <= 4'd0;
      tx_state <= TX_START;
`ifdef SPART_PARITY_EN
      tx_par   <= ^tx_head;
`endif
    end else if ((tx_state != TX_IDLE) && tick) begin
      if (tx_tick != LAST_TICK) begin
        tx_tick <= tx_tick + 4'd1;
      end else begin
        tx_tick <= 4'd0;
        case (tx_state)
          TX_START: begin
            txd      <= tx_shift[0];
            tx_bit   <= 3'd0;
            tx_state <= TX_DATA;
          end
          TX_DATA: begin
            if (tx_bit == LAST_BIT) begin
`ifdef SPART_PARITY_EN
              txd      <= tx_par;
              tx_state <= TX_PARITY;
`else
              txd      <= 1'b1;
              tx_state <= TX_STOP;
`endif
            end else begin
              txd      <= tx_shift[1];
              tx_shift <= tx_shift >> 1;
              tx_bit   <= tx_bit + 3'd1;
            end
          end
          TX_PARITY: begin
            txd      <= 1'b1;
            tx_state <= TX_STOP;
          end
          default: begin
            txd      <= 1'b1;
            tx_state <= TX_IDLE;
          end
        endcase
      end
    end
  end

  // Receiver: confirm start at mid-bit, then sample every 16 ticks LSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      rx_tick  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= '0;
`ifdef SPART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      case (rx_state)
        RX_IDLE: begin
          if (!rxd_s) begin
            rx_state <= RX_START;
            rx_tick  <= 4'd0;
          end
        end
        RX_BREAK: begin
          if (rxd_s) rx_state <= RX_IDLE;
        end
        RX_START: begin
          if (tick) begin
            if (rx_tick == MID_TICK) begin
              rx_tick  <= 4'd0;
              rx_bit   <= 3'd0;
              rx_state <= rxd_s ? RX_IDLE : RX_DATA;
            end else begin
              rx_tick <= rx_tick + 4'd1;
            end
          end
        end
        default: begin
          if (tick) begin
            if (rx_tick != LAST_TICK) begin
              rx_tick <= rx_tick + 4'd1;
            end else begin
              rx_tick <= 4'd0;
              case (rx_state)
                RX_DATA: begin
                  rx_shift <= {rxd_s, rx_shift[DATA_BITS-1:1]};
                  rx_bit   <= rx_bit + 3'd1;
                  if (rx_bit == LAST_BIT) begin
`ifdef SPART_PARITY_EN
                    rx_state <= RX_PARITY;
`else
                    rx_state <= RX_STOP;
`endif
                  end
                end
                RX_PARITY: begin
`ifdef SPART_PARITY_EN
                  rx_par   <= rxd_s;
`endif
                  rx_state <= RX_STOP;
                end
                default: rx_state <= rxd_s ? RX_IDLE : RX_BREAK;
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule
